// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage hazard controller: forwarding selects, load-use stall FSM, stall counter
// Operands are bypassed from EXE/MEM by register match; loads in EXE stall decode for LOAD_LAT cycles.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic [REG_AW-1:0] rd_EXE,
  input  logic              regwrite_EXE,
  input  logic              memread_EXE,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic              regwrite_MEM,
  input  logic              branch_taken_D,
  input  logic              cnt_clr,
  output logic              Sel_Rs1D,
  output logic              Sel_Rs2D,
  output logic [1:0]        Sel_Comp_Rs1D,
  output logic [1:0]        Sel_Comp_Rs2D,
  output logic              stall_F,
  output logic              stall_D,
  output logic              flush_EXE,
  output logic              flush_D,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic hit_exe_rs1, hit_exe_rs2, hit_mem_rs1, hit_mem_rs2;
  logic load_use;
  logic stall;
  logic [1:0] comp_rs1, comp_rs2;

  // x0 is hard-wired zero, so a write to it never produces a forwardable value.
  always_comb begin
    hit_exe_rs1 = regwrite_EXE & use_rs1 & (rd_EXE != '0) & (rd_EXE == rs1);
    hit_exe_rs2 = regwrite_EXE & use_rs2 & (rd_EXE != '0) & (rd_EXE == rs2);
    hit_mem_rs1 = regwrite_MEM & use_rs1 & (rd_MEM != '0) & (rd_MEM == rs1);
    hit_mem_rs2 = regwrite_MEM & use_rs2 & (rd_MEM != '0) & (rd_MEM == rs2);
    load_use    = memread_EXE & (hit_exe_rs1 | hit_exe_rs2);
  end

  // EXE holds the younger producer, so it wins over MEM.
  always_comb begin
    comp_rs1 = 2'b00;
    comp_rs2 = 2'b00;
    if (hit_exe_rs1)      comp_rs1 = 2'b01;
    else if (hit_mem_rs1) comp_rs1 = 2'b10;
    if (hit_exe_rs2)      comp_rs2 = 2'b01;
    else if (hit_mem_rs2) comp_rs2 = 2'b10;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_use) begin
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = CNT_INIT;
          end
        end
      end
      STALL: begin
        // load_use is deliberately ignored here; it is re-evaluated once back in IDLE.
        stall = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (cnt_clr)
      stall_cycles_d = '0;
    else if (stall && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 2'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Every output is held low while reset is asserted, combinational paths included.
  always_comb begin
    Sel_Rs1D      = ~rst & hit_mem_rs1;
    Sel_Rs2D      = ~rst & hit_mem_rs2;
    Sel_Comp_Rs1D = {2{~rst}} & comp_rs1;
    Sel_Comp_Rs2D = {2{~rst}} & comp_rs2;
    stall_F       = ~rst & stall;
    stall_D       = ~rst & stall;
    flush_EXE     = ~rst & stall;
    flush_D       = ~rst & branch_taken_D & ~stall;
    stall_cycles  = rst ? '0 : stall_cycles_q;
  end

endmodule
